// File: rtl/bresenham_draw_engine.sv
// Bresenham line / full-frame clear pixel generator for a plot-style framebuffer port.
// Off-screen line pixels are skipped without a strobe; clear mode walks the raster.
module bresenham_draw_engine #(
    parameter int X_WIDTH     = 8,
    parameter int Y_WIDTH     = 7,
    parameter int COLOR_WIDTH = 3,
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic [X_WIDTH-1:0]     x0,
    input  logic [Y_WIDTH-1:0]     y0,
    input  logic [X_WIDTH-1:0]     x1,
    input  logic [Y_WIDTH-1:0]     y1,
    input  logic [COLOR_WIDTH-1:0] color_in,
    input  logic                   plot_ready,
    output logic [X_WIDTH-1:0]     x_out,
    output logic [Y_WIDTH-1:0]     y_out,
    output logic [COLOR_WIDTH-1:0] color,
    output logic                   write_out,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
    typedef logic signed [CW-1:0] coord_t;

    localparam coord_t X_LIM = coord_t'(X_MAX);
    localparam coord_t Y_LIM = coord_t'(Y_MAX);
    localparam coord_t ONE   = coord_t'(1);
    localparam coord_t ZERO  = coord_t'(0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LINE_INIT = 3'd1,
        LINE_DRAW = 3'd2,
        CLEAR     = 3'd3,
        FINISH    = 3'd4
    } state_t;

    function automatic coord_t ext_x(input logic [X_WIDTH-1:0] v);
        return coord_t'({{(CW-X_WIDTH){1'b0}}, v});
    endfunction

    function automatic coord_t ext_y(input logic [Y_WIDTH-1:0] v);
        return coord_t'({{(CW-Y_WIDTH){1'b0}}, v});
    endfunction

    state_t                 state_q, state_d;
    coord_t                 x_q, x_d, y_q, y_d;
    coord_t                 x1_q, x1_d, y1_q, y1_d;
    coord_t                 dx_q, dx_d, dy_q, dy_d;
    coord_t                 sx_q, sx_d, sy_q, sy_d;
    coord_t                 err_q, err_d;
    logic [COLOR_WIDTH-1:0] color_q, color_d;
    logic [X_WIDTH-1:0]     x_out_q, x_out_d;
    logic [Y_WIDTH-1:0]     y_out_q, y_out_d;
    logic                   write_q, write_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic signed [CW:0]     e2_s, dx_w_s, dy_w_s;
    logic                   step_x_s, step_y_s;

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= ZERO;
            y_q     <= ZERO;
            x1_q    <= ZERO;
            y1_q    <= ZERO;
            dx_q    <= ZERO;
            dy_q    <= ZERO;
            sx_q    <= ZERO;
            sy_q    <= ZERO;
            err_q   <= ZERO;
            color_q <= {COLOR_WIDTH{1'b0}};
            x_out_q <= {X_WIDTH{1'b0}};
            y_out_q <= {Y_WIDTH{1'b0}};
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            err_q   <= err_d;
            color_q <= color_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, Bresenham step and registered-output computation
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        err_d   = err_q;
        color_d = color_q;

        // Doubled error needs one extra bit so 2*err never wraps.
        e2_s     = {err_q, 1'b0};
        dx_w_s   = {dx_q[CW-1], dx_q};
        dy_w_s   = {dy_q[CW-1], dy_q};
        step_x_s = (e2_s >= dy_w_s);
        step_y_s = (e2_s <= dx_w_s);

        case (state_q)
            IDLE: begin
                if (start) begin
                    x1_d    = ext_x(x1);
                    y1_d    = ext_y(y1);
                    color_d = color_in;
                    if (mode) begin
                        x_d     = ZERO;
                        y_d     = ZERO;
                        state_d = CLEAR;
                    end else begin
                        x_d     = ext_x(x0);
                        y_d     = ext_y(y0);
                        state_d = LINE_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LINE_INIT: begin
                if (x_q < x1_q) begin
                    dx_d = x1_q - x_q;
                    sx_d = ONE;
                end else begin
                    dx_d = x_q - x1_q;
                    sx_d = -ONE;
                end
                if (y_q < y1_q) begin
                    dy_d = y_q - y1_q;
                    sy_d = ONE;
                end else begin
                    dy_d = y1_q - y_q;
                    sy_d = -ONE;
                end
                err_d   = dx_d + dy_d;
                state_d = LINE_DRAW;
            end
            LINE_DRAW: begin
                if (!write_q || plot_ready) begin
                    if ((x_q == x1_q) && (y_q == y1_q)) begin
                        state_d = FINISH;
                    end else begin
                        err_d = err_q + (step_x_s ? dy_q : ZERO) + (step_y_s ? dx_q : ZERO);
                        x_d   = step_x_s ? (x_q + sx_q) : x_q;
                        y_d   = step_y_s ? (y_q + sy_q) : y_q;
                    end
                end else begin
                    state_d = LINE_DRAW;
                end
            end
            CLEAR: begin
                if (plot_ready) begin
                    if (x_q == X_LIM) begin
                        x_d = ZERO;
                        if (y_q == Y_LIM) begin
                            state_d = FINISH;
                        end else begin
                            y_d = y_q + ONE;
                        end
                    end else begin
                        x_d = x_q + ONE;
                    end
                end else begin
                    state_d = CLEAR;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        x_out_d = x_d[X_WIDTH-1:0];
        y_out_d = y_d[Y_WIDTH-1:0];
        write_d = (state_d == CLEAR) ||
                  ((state_d == LINE_DRAW) && (x_d <= X_LIM) && (y_d <= Y_LIM));
        busy_d  = (state_d == LINE_INIT) || (state_d == LINE_DRAW) || (state_d == CLEAR);
        done_d  = (state_d == FINISH);
    end

    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign color     = color_q;
    assign write_out = write_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bresenham_draw_engine.sv
// Directed scoreboard bench for bresenham_draw_engine: expected pixels are queued
// before each operation and popped as the sink accepts strobed pixels.
module tb_bresenham_draw_engine;

    logic       clk = 1'b0;
    logic       reset, start, mode, plot_ready;
    logic [7:0] x0, x1, x_out;
    logic [6:0] y0, y1, y_out;
    logic [2:0] color_in, color;
    logic       write_out, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_wr_cyc = -1;

    logic [17:0] sb[$];

    logic       prev_w = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
    logic [7:0] prev_x = 8'd0;
    logic [6:0] prev_y = 7'd0;

    bresenham_draw_engine #(
        .X_WIDTH(8), .Y_WIDTH(7), .COLOR_WIDTH(3), .X_MAX(159), .Y_MAX(119)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color_in(color_in),
        .plot_ready(plot_ready), .x_out(x_out), .y_out(y_out), .color(color),
        .write_out(write_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_px(input int px, input int py, input logic [2:0] c);
        logic [7:0] xx;
        logic [6:0] yy;
        xx = 8'(px);
        yy = 7'(py);
        sb.push_back({xx, yy, c});
    endtask

    // Output monitor: scoreboard pop on accepted pixels, done tracking, stall-hold check
    always @(negedge clk) begin
        if (write_out && plot_ready) begin
            acc_cnt++;
            chk("pixel_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) chk("pixel_xyc", 64'({x_out, y_out, color}), 64'(sb.pop_front()));
        end
        if (write_out && first_wr_cyc < 0) first_wr_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_w && !prev_r && !prev_rst && !reset)
            chk("stall_hold", 64'({x_out, y_out, write_out}), 64'({prev_x, prev_y, 1'b1}));
        prev_w   = write_out;
        prev_r   = plot_ready;
        prev_rst = reset;
        prev_x   = x_out;
        prev_y   = y_out;
    end

    // bp: 0 = always ready, 1 = toggling 1,0,1,0..., 2 = random
    task automatic do_op(input logic m, input int ax0, input int ay0, input int ax1, input int ay1,
                         input logic [2:0] c, input int bp, input int budget,
                         input int first_off, input int done_off, input bit poke);
        int acc, d0, a0, n0;
        n0 = sb.size();
        d0 = done_cnt;
        a0 = acc_cnt;
        @(posedge clk); #1;
        mode = m; x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1);
        color_in = c; start = 1'b1; first_wr_cyc = -1;
        @(posedge clk); #1;
        acc = cyc;
        start = 1'b0;
        x0 = 8'hA5; y0 = 7'h55; x1 = 8'h11; y1 = 7'h22; color_in = ~c;
        for (int i = 0; i < budget; i++) begin
            case (bp)
                1:       plot_ready = (i % 2 == 0);
                2:       plot_ready = 1'($urandom_range(0, 1));
                default: plot_ready = 1'b1;
            endcase
            if (poke && i == 2) begin
                start = 1'b1;
                mode  = ~m;
            end else if (poke && i == 3) begin
                start = 1'b0;
            end
            @(negedge clk); #1;
            if (done_cnt != d0) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("pixel_count", 64'(acc_cnt - a0), 64'(n0));
        chk("sb_empty", 64'(sb.size()), 64'd0);
        if (first_off >= 0) chk("first_write_latency", 64'(first_wr_cyc - acc), 64'(first_off));
        if (done_off >= 0) chk("done_latency", 64'(done_cyc - acc), 64'(done_off));
        @(posedge clk); #1;
        plot_ready = 1'b1;
        @(negedge clk); #1;
        chk("done_pulse_width", 64'({done, busy}), 64'd0);
        sb.delete();
    endtask

    initial begin
        int sx[6], sy[6];
        int d0;
        reset = 1'b1; start = 1'b0; mode = 1'b0; plot_ready = 1'b1;
        x0 = 8'd0; y0 = 7'd0; x1 = 8'd0; y1 = 7'd0; color_in = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({x_out, y_out, color, write_out, busy, done}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // horizontal line with latency checks
        for (int i = 0; i < 4; i++) push_px(i, 0, 3'b011);
        do_op(1'b0, 0, 0, 3, 0, 3'b011, 0, 40, 1, 5, 1'b0);

        // steep line
        sx = '{2, 2, 3, 3, 4, 4}; sy = '{1, 2, 3, 4, 5, 6};
        for (int i = 0; i < 6; i++) push_px(sx[i], sy[i], 3'b110);
        do_op(1'b0, 2, 1, 4, 6, 3'b110, 0, 40, 1, 7, 1'b0);

        // reversed steep line
        sx = '{4, 4, 3, 3, 2, 2}; sy = '{6, 5, 4, 3, 2, 1};
        for (int i = 0; i < 6; i++) push_px(sx[i], sy[i], 3'b001);
        do_op(1'b0, 4, 6, 2, 1, 3'b001, 0, 40, 1, 7, 1'b0);

        // shallow line
        sx = '{0, 1, 2, 3, 4, 5}; sy = '{0, 0, 1, 1, 2, 2};
        for (int i = 0; i < 6; i++) push_px(sx[i], sy[i], 3'b010);
        do_op(1'b0, 0, 0, 5, 2, 3'b010, 0, 40, 1, 7, 1'b0);

        // backpressure toggling, with start pulses while busy
        for (int i = 0; i < 4; i++) push_px(i, 0, 3'b100);
        do_op(1'b0, 0, 0, 3, 0, 3'b100, 1, 40, 1, -1, 1'b1);

        // random backpressure on the steep line
        sx = '{2, 2, 3, 3, 4, 4}; sy = '{1, 2, 3, 4, 5, 6};
        for (int i = 0; i < 6; i++) push_px(sx[i], sy[i], 3'b111);
        do_op(1'b0, 2, 1, 4, 6, 3'b111, 2, 100, 1, -1, 1'b0);

        // clipped line: only x=150..159 strobe, done after stepping to x=200
        for (int i = 150; i <= 159; i++) push_px(i, 100, 3'b011);
        do_op(1'b0, 150, 100, 200, 100, 3'b011, 0, 120, 1, 52, 1'b0);

        // single point
        push_px(5, 5, 3'b010);
        do_op(1'b0, 5, 5, 5, 5, 3'b010, 0, 20, 1, 2, 1'b0);

        // full clear
        for (int yy = 0; yy <= 119; yy++)
            for (int xx = 0; xx <= 159; xx++) push_px(xx, yy, 3'b101);
        do_op(1'b1, 0, 0, 0, 0, 3'b101, 0, 19300, 0, 19200, 1'b0);

        // clear interrupted by reset at pixel 50
        for (int i = 0; i < 100; i++) push_px(i, 0, 3'b110);
        d0 = done_cnt;
        @(posedge clk); #1;
        mode = 1'b1; color_in = 3'b110; start = 1'b1; plot_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && acc_cnt % 1000000 >= 0; i++) begin
            if (sb.size() <= 50) break;
            @(posedge clk); #1;
        end
        chk("reset_point_reached", 64'(sb.size()), 64'd50);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midop_reset_outputs", 64'({x_out, y_out, color, write_out, busy, done}), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("midop_reset_no_done", 64'(done_cnt - d0), 64'd0);
        chk("midop_reset_idle", 64'({busy, write_out}), 64'd0);
        sb.delete();

        // normal operation after reset
        sx = '{2, 2, 3, 3, 4, 4}; sy = '{1, 2, 3, 4, 5, 6};
        for (int i = 0; i < 6; i++) push_px(sx[i], sy[i], 3'b011);
        do_op(1'b0, 2, 1, 4, 6, 3'b011, 0, 40, 1, 7, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
